// File: rtl/obi_traffic_gen_pkg.sv
// Shared definitions for the OBI write-then-readback traffic generator:
// FSM state encoding and the per-word data pattern.
package obi_traffic_gen_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    WAIT_W = 3'd2,
    READ   = 3'd3,
    WAIT_R = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Widest address/data the pattern helper handles; callers cast in and out.
  localparam int unsigned PatWidth = 128;

  function automatic logic [PatWidth-1:0] obi_pattern(input logic [PatWidth-1:0] addr,
                                                      input logic [PatWidth-1:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/obi_outstanding_cnt.sv
// Counts granted-but-unanswered OBI transfers; a response with nothing
// outstanding is ignored so the count never underflows.
module obi_outstanding_cnt #(
  parameter int unsigned Max = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] count,
  output logic       full,
  output logic       empty
);

  logic dec_eff;

  assign dec_eff = dec && (count != 4'd0);
  assign full    = (count >= 4'(Max));
  assign empty   = (count == 4'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= 4'd0;
    end else if (inc && !dec_eff) begin
      count <= count + 4'd1;
    end else if (!inc && dec_eff) begin
      count <= count - 4'd1;
    end
  end

endmodule

// File: rtl/obi_traffic_gen.sv
// OBI manager that writes N pattern words then reads them back and compares.
// Define OBI_TRAFFIC_GEN_RANDOM_STALL_EN to gate new requests with an LFSR.
module obi_traffic_gen
  import obi_traffic_gen_pkg::*;
#(
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          DataWidth      = 64,
  parameter logic [AddrWidth-1:0] BaseAddr       = '0,
  parameter int unsigned          MaxOutstanding = 4,
  parameter logic [DataWidth-1:0] PatternSeed    = 64'hA5A5_0000_5A5A_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [15:0]            num_words_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   mismatch_o,
  output logic                   proto_err_o,
  output logic [15:0]            err_count_o,
  output logic                   req_o,
  output logic [AddrWidth-1:0]   addr_o,
  output logic                   we_o,
  output logic [DataWidth/8-1:0] be_o,
  output logic [DataWidth-1:0]   wdata_o,
  input  logic                   gnt_i,
  input  logic                   rvalid_i,
  input  logic [DataWidth-1:0]   rdata_i
);

  localparam int unsigned StrideLog2 = $clog2(DataWidth / 8);

  function automatic logic [AddrWidth-1:0] word_addr(input logic [15:0] i);
    return BaseAddr + (AddrWidth'(i) << StrideLog2);
  endfunction

  function automatic logic [DataWidth-1:0] pattern_of(input logic [AddrWidth-1:0] a);
    return DataWidth'(obi_pattern(PatWidth'(a), PatWidth'(PatternSeed)));
  endfunction

  state_e               state;
  logic [15:0]          num_words;
  logic [15:0]          idx;
  logic [15:0]          rd_idx;
  logic [3:0]           cnt;
  logic                 cnt_full;
  logic                 cnt_empty;
  logic                 granted;
  logic                 rsp_ok;
  logic                 issuing;
  logic                 last_grant;
  logic                 room;
  logic                 drained;
  logic                 launch;
  logic                 lfsr_ok;
  logic                 compare_hit;
  logic [15:0]          idx_n;
  logic [DataWidth-1:0] rd_expect;

  obi_outstanding_cnt #(.Max(MaxOutstanding)) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (granted),
    .dec   (rvalid_i),
    .count (cnt),
    .full  (cnt_full),
    .empty (cnt_empty)
  );

`ifdef OBI_TRAFFIC_GEN_RANDOM_STALL_EN
  localparam logic [15:0] LfsrReset = 16'hACE1;
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr <= LfsrReset;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign lfsr_ok = lfsr[0];
`else
  assign lfsr_ok = 1'b1;
`endif

  assign granted    = req_o && gnt_i;
  assign rsp_ok     = rvalid_i && !cnt_empty;
  assign issuing    = (state == WRITE) || (state == READ);
  assign last_grant = granted && (idx == num_words - 16'd1);
  assign idx_n      = granted ? idx + 16'd1 : idx;
  // Room is judged on the count as it will be after this edge's grant/response.
  assign room       = rsp_ok || (granted ? (cnt < 4'(MaxOutstanding - 1)) : !cnt_full);
  assign launch     = issuing && !last_grant && (!req_o || granted) && room && lfsr_ok;
  assign drained    = cnt_empty || ((cnt == 4'd1) && rvalid_i);
  assign compare_hit = rsp_ok && ((state == READ) || (state == WAIT_R));
  assign rd_expect  = pattern_of(word_addr(rd_idx));

  assign busy_o = issuing || (state == WAIT_W) || (state == WAIT_R);
  assign done_o = (state == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      num_words   <= 16'd0;
      idx         <= 16'd0;
      rd_idx      <= 16'd0;
      req_o       <= 1'b0;
      addr_o      <= '0;
      we_o        <= 1'b0;
      be_o        <= '0;
      wdata_o     <= '0;
      mismatch_o  <= 1'b0;
      proto_err_o <= 1'b0;
      err_count_o <= 16'd0;
    end else begin
      if (rvalid_i && cnt_empty) begin
        proto_err_o <= 1'b1;
      end
      if (compare_hit) begin
        rd_idx <= rd_idx + 16'd1;
        if (rdata_i != rd_expect) begin
          mismatch_o <= 1'b1;
          if (err_count_o != 16'hFFFF) begin
            err_count_o <= err_count_o + 16'd1;
          end
        end
      end
      if (launch) begin
        req_o   <= 1'b1;
        addr_o  <= word_addr(idx_n);
        we_o    <= (state == WRITE);
        be_o    <= '1;
        wdata_o <= (state == WRITE) ? pattern_of(word_addr(idx_n)) : '0;
      end else if (granted) begin
        req_o <= 1'b0;
      end
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            num_words   <= num_words_i;
            idx         <= 16'd0;
            rd_idx      <= 16'd0;
            mismatch_o  <= 1'b0;
            err_count_o <= 16'd0;
            state       <= (num_words_i == 16'd0) ? DONE : WRITE;
          end
        end
        WRITE: begin
          if (last_grant) begin
            idx   <= 16'd0;
            state <= WAIT_W;
          end else begin
            idx <= idx_n;
          end
        end
        WAIT_W: if (drained) state <= READ;
        READ: begin
          if (last_grant) begin
            idx   <= 16'd0;
            state <= WAIT_R;
          end else begin
            idx <= idx_n;
          end
        end
        WAIT_R: if (drained) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
